// File: rtl/sap_pkg.sv
// Shared types and sizes for the SAP-1 program/data RAM and its byte-stream loader.
package sap_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] sap_word_t;
  typedef logic [ADDR_W-1:0] sap_addr_t;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PROG = 2'd1,
    DONE = 2'd2
  } ram_state_t;

endpackage

// File: rtl/sap_ram_loader.sv
// Loader FSM: owns the RUN/PROG/DONE state, the auto-incrementing load address and
// the valid/ready handshake, and hands a write strobe/address/data to the RAM.
//
// state | meaning
// RUN   | RAM answers the MAR; loader idle
// PROG  | accepting bytes into prog_addr, ready high
// DONE  | all DEPTH words loaded; waiting for prog_mode to drop
module sap_ram_loader
  import sap_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       prog_mode,
  input  logic       prog_valid,
  input  sap_word_t  prog_data,
  output ram_state_t state,
  output logic       prog_ready,
  output logic       prog_done,
  output sap_addr_t  prog_addr,
  output logic       wr_en,
  output sap_addr_t  wr_addr,
  output sap_word_t  wr_data
);

  ram_state_t state_q, state_d;
  sap_addr_t  addr_q, addr_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wr_en   = 1'b0;
    case (state_q)
      RUN: begin
        if (prog_mode) begin
          state_d = PROG;
          addr_d  = '0;
        end
      end
      PROG: begin
        // Dropping prog_mode wins over a byte presented on the same edge.
        if (!prog_mode) begin
          state_d = RUN;
        end else if (prog_valid) begin
          wr_en  = 1'b1;
          addr_d = addr_q + 1'b1;
          if (addr_q == sap_addr_t'(DEPTH - 1)) state_d = DONE;
        end
      end
      DONE: begin
        if (!prog_mode) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign state      = state_q;
  assign prog_ready = (state_q == PROG);
  assign prog_done  = (state_q == DONE);
  assign prog_addr  = addr_q;
  assign wr_addr    = addr_q;
  assign wr_data    = prog_data;

endmodule

// File: rtl/sap_ram.sv
// SAP-1 16x8 RAM: MAR-addressed read/write in RUN, filled by the stream loader in PROG.
// Reads register the old word, so a same-address read+write returns pre-write data.
module sap_ram
  import sap_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] mar_address,
  input  logic              ce,
  input  logic              we,
  input  logic [DATA_W-1:0] w_bus_in,
  output logic [DATA_W-1:0] w_bus_out,
  output logic              w_bus_oe,
  input  logic              prog_mode,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done,
  output logic [ADDR_W-1:0] prog_addr
);

  ram_state_t state;
  logic       ld_wr_en;
  sap_addr_t  ld_wr_addr;
  sap_word_t  ld_wr_data;

  sap_ram_loader u_loader (
    .clk        (clk),
    .reset_n    (reset_n),
    .prog_mode  (prog_mode),
    .prog_valid (prog_valid),
    .prog_data  (prog_data),
    .state      (state),
    .prog_ready (prog_ready),
    .prog_done  (prog_done),
    .prog_addr  (prog_addr),
    .wr_en      (ld_wr_en),
    .wr_addr    (ld_wr_addr),
    .wr_data    (ld_wr_data)
  );

  sap_word_t mem_q [DEPTH];
  sap_word_t mem_d [DEPTH];
  sap_word_t rdata_q, rdata_d;
  logic      oe_q, oe_d;
  logic      run_active;

  // The edge that enters PROG must not also service the MAR.
  assign run_active = (state == RUN) && !prog_mode;

  always_comb begin
    mem_d   = mem_q;
    rdata_d = rdata_q;
    oe_d    = 1'b0;
    if (run_active && ce) begin
      rdata_d = mem_q[mar_address];
      oe_d    = 1'b1;
    end
    if (ld_wr_en) begin
      mem_d[ld_wr_addr] = ld_wr_data;
    end else if (run_active && we) begin
      mem_d[mar_address] = w_bus_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
      oe_q    <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
      oe_q    <= oe_d;
    end
  end

  assign w_bus_out = rdata_q;
  assign w_bus_oe  = oe_q;

endmodule

// File: tb/tb_sap_ram.sv
// Directed bench for sap_ram: reset, full/partial loads, RUN read/write, ignored requests.
module tb_sap_ram;

  logic       clk;
  logic       reset_n;
  logic [3:0] mar_address;
  logic       ce;
  logic       we;
  logic [7:0] w_bus_in;
  logic [7:0] w_bus_out;
  logic       w_bus_oe;
  logic       prog_mode;
  logic       prog_valid;
  logic [7:0] prog_data;
  logic       prog_ready;
  logic       prog_done;
  logic [3:0] prog_addr;

  int n_cmp;
  int n_bad;

  sap_ram dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mar_address (mar_address),
    .ce          (ce),
    .we          (we),
    .w_bus_in    (w_bus_in),
    .w_bus_out   (w_bus_out),
    .w_bus_oe    (w_bus_oe),
    .prog_mode   (prog_mode),
    .prog_valid  (prog_valid),
    .prog_data   (prog_data),
    .prog_ready  (prog_ready),
    .prog_done   (prog_done),
    .prog_addr   (prog_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle ce pulse; returns data/oe one cycle later and oe the cycle after.
  task automatic do_read(input logic [3:0] a, output logic [7:0] d, output logic oe1, output logic oe2);
    mar_address = a;
    ce = 1'b1;
    tick();
    d   = w_bus_out;
    oe1 = w_bus_oe;
    ce  = 1'b0;
    tick();
    oe2 = w_bus_oe;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic oe1, oe2;
    int bad;
    #3 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({w_bus_out, w_bus_oe, prog_ready, prog_done, prog_addr} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: out=%h oe=%b rdy=%b done=%b addr=%h, want all zero",
               w_bus_out, w_bus_oe, prog_ready, prog_done, prog_addr);
    end
    #2 reset_n = 1'b1;
    tick();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      do_read(4'(i), d, oe1, oe2);
      if (d !== 8'h00 || oe1 !== 1'b1 || oe2 !== 1'b0) begin
        bad++;
        $display("FAIL reset_read[%0d]: data=%h oe=%b/%b, want 00 oe=1/0", i, d, oe1, oe2);
      end
    end
    n_cmp++;
    if (bad != 0) n_bad++;
  endtask

  task automatic test_prog_full();
    logic [7:0] d;
    logic oe1, oe2;
    int accepts;
    prog_mode = 1'b1;
    tick();
    n_cmp++;
    if (prog_ready !== 1'b1 || prog_addr !== 4'd0 || prog_done !== 1'b0) begin
      n_bad++;
      $display("FAIL prog_enter: rdy=%b addr=%h done=%b, want 1 0 0", prog_ready, prog_addr, prog_done);
    end
    accepts = 0;
    prog_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      prog_data = 8'h10 + 8'(i);
      if (prog_ready === 1'b1 && prog_done === 1'b0 && prog_addr === 4'(i)) accepts++;
      tick();
    end
    prog_valid = 1'b0;
    n_cmp++;
    if (accepts !== 16) begin
      n_bad++;
      $display("FAIL prog_accepts: got %0d ready/addr-matching accepts, want 16", accepts);
    end
    n_cmp++;
    if (prog_done !== 1'b1 || prog_ready !== 1'b0 || prog_addr !== 4'd0) begin
      n_bad++;
      $display("FAIL prog_done: done=%b rdy=%b addr=%h, want 1 0 0", prog_done, prog_ready, prog_addr);
    end
    prog_mode = 1'b0;
    tick();
    n_cmp++;
    if (prog_done !== 1'b0 || prog_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL prog_exit: done=%b rdy=%b, want 0 0", prog_done, prog_ready);
    end
    do_read(4'd5, d, oe1, oe2);
    n_cmp++;
    if (d !== 8'h15 || oe1 !== 1'b1 || oe2 !== 1'b0) begin
      n_bad++;
      $display("FAIL prog_read5: data=%h oe=%b/%b, want 15 oe=1/0", d, oe1, oe2);
    end
    do_read(4'd15, d, oe1, oe2);
    n_cmp++;
    if (d !== 8'h1F) begin
      n_bad++;
      $display("FAIL prog_read15: data=%h, want 1f", d);
    end
  endtask

  task automatic test_prog_toggle_abort();
    logic [7:0] d;
    logic oe1, oe2;
    logic [7:0] vals [4];
    logic [7:0] exp  [4];
    logic [3:0] exp_addr [6];
    logic       vld [6];
    int bad;
    vals[0] = 8'hAA; vals[1] = 8'hBB; vals[2] = 8'hCC; vals[3] = 8'hDD;
    exp[0]  = 8'hAA; exp[1]  = 8'hBB; exp[2]  = 8'hCC; exp[3]  = 8'h13;
    vld[0] = 1; vld[1] = 0; vld[2] = 1; vld[3] = 0; vld[4] = 1; vld[5] = 0;
    exp_addr[0] = 4'd1; exp_addr[1] = 4'd1; exp_addr[2] = 4'd2;
    exp_addr[3] = 4'd2; exp_addr[4] = 4'd3; exp_addr[5] = 4'd3;
    prog_mode = 1'b1;
    tick();
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      prog_valid = vld[i];
      prog_data  = vld[i] ? vals[i/2] : 8'hEE;
      tick();
      if (prog_addr !== exp_addr[i]) begin
        bad++;
        $display("FAIL toggle_addr[%0d]: addr=%h, want %h", i, prog_addr, exp_addr[i]);
      end
    end
    n_cmp++;
    if (bad != 0) n_bad++;
    prog_valid = 1'b1;
    prog_data  = vals[3];
    prog_mode  = 1'b0;
    tick();
    prog_valid = 1'b0;
    n_cmp++;
    if (prog_done !== 1'b0 || prog_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_state: done=%b rdy=%b, want 0 0", prog_done, prog_ready);
    end
    for (int i = 0; i < 4; i++) begin
      do_read(4'(i), d, oe1, oe2);
      n_cmp++;
      if (d !== exp[i] || oe1 !== 1'b1) begin
        n_bad++;
        $display("FAIL abort_read[%0d]: data=%h oe=%b, want %h oe=1", i, d, oe1, exp[i]);
      end
    end
  endtask

  task automatic test_run_rw();
    logic [7:0] d;
    logic oe1, oe2;
    mar_address = 4'd7;
    w_bus_in    = 8'h5A;
    we          = 1'b1;
    tick();
    we = 1'b0;
    do_read(4'd7, d, oe1, oe2);
    n_cmp++;
    if (d !== 8'h5A || oe1 !== 1'b1) begin
      n_bad++;
      $display("FAIL run_write_read: data=%h oe=%b, want 5a oe=1", d, oe1);
    end
    mar_address = 4'd7;
    w_bus_in    = 8'h33;
    ce          = 1'b1;
    we          = 1'b1;
    tick();
    we = 1'b0;
    n_cmp++;
    if (w_bus_out !== 8'h5A || w_bus_oe !== 1'b1) begin
      n_bad++;
      $display("FAIL run_rw_same: data=%h oe=%b, want old 5a oe=1", w_bus_out, w_bus_oe);
    end
    tick();
    ce = 1'b0;
    n_cmp++;
    if (w_bus_out !== 8'h33 || w_bus_oe !== 1'b1) begin
      n_bad++;
      $display("FAIL run_back_to_back: data=%h oe=%b, want 33 oe=1", w_bus_out, w_bus_oe);
    end
    tick();
    n_cmp++;
    if (w_bus_oe !== 1'b0 || w_bus_out !== 8'h33) begin
      n_bad++;
      $display("FAIL run_oe_drop: data=%h oe=%b, want held 33 oe=0", w_bus_out, w_bus_oe);
    end
  endtask

  task automatic test_ignore_prog_done();
    logic [7:0] d;
    logic oe1, oe2;
    int bad;
    // PROG: requests on the entry edge and in PROG are ignored, then abort.
    mar_address = 4'd7;
    w_bus_in    = 8'hEE;
    prog_mode   = 1'b1;
    ce          = 1'b1;
    we          = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (w_bus_oe !== 1'b0) bad++;
    end
    ce = 1'b0;
    we = 1'b0;
    prog_mode = 1'b0;
    tick();
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL prog_ignore_oe: %0d cycles with oe high, want 0", bad);
    end
    do_read(4'd7, d, oe1, oe2);
    n_cmp++;
    if (d !== 8'h33) begin
      n_bad++;
      $display("FAIL prog_ignore_mem: data=%h, want 33", d);
    end
    // Full load of 0x40.., then requests in DONE.
    prog_mode = 1'b1;
    tick();
    prog_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      prog_data = 8'h40 + 8'(i);
      tick();
    end
    prog_data   = 8'hFF;
    mar_address = 4'd7;
    ce          = 1'b1;
    we          = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (w_bus_oe !== 1'b0 || prog_done !== 1'b1 || prog_ready !== 1'b0 || prog_addr !== 4'd0) bad++;
    end
    ce = 1'b0;
    we = 1'b0;
    prog_valid = 1'b0;
    prog_mode  = 1'b0;
    tick();
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL done_ignore: %0d bad cycles (oe/done/ready/addr), want 0", bad);
    end
    do_read(4'd7, d, oe1, oe2);
    n_cmp++;
    if (d !== 8'h47) begin
      n_bad++;
      $display("FAIL done_mem7: data=%h, want 47", d);
    end
    do_read(4'd0, d, oe1, oe2);
    n_cmp++;
    if (d !== 8'h40) begin
      n_bad++;
      $display("FAIL done_mem0: data=%h, want 40", d);
    end
  endtask

  task automatic test_reset_mid_prog();
    logic [7:0] d;
    logic oe1, oe2;
    int bad;
    prog_mode = 1'b1;
    tick();
    prog_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      prog_data = 8'h60 + 8'(i);
      tick();
    end
    prog_valid = 1'b0;
    n_cmp++;
    if (prog_addr !== 4'd8 || prog_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midprog_addr: addr=%h rdy=%b, want 8 1", prog_addr, prog_ready);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (prog_ready !== 1'b0 || prog_addr !== 4'd0 || prog_done !== 1'b0 || w_bus_oe !== 1'b0) begin
      n_bad++;
      $display("FAIL midprog_reset: rdy=%b addr=%h done=%b oe=%b, want 0 0 0 0",
               prog_ready, prog_addr, prog_done, w_bus_oe);
    end
    prog_mode = 1'b0;
    #1 reset_n = 1'b1;
    tick();
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      do_read(4'(i), d, oe1, oe2);
      if (d !== 8'h00 || oe1 !== 1'b1) begin
        bad++;
        $display("FAIL midprog_read[%0d]: data=%h oe=%b, want 00 oe=1", i, d, oe1);
      end
    end
    n_cmp++;
    if (bad != 0) n_bad++;
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    reset_n     = 1'b1;
    mar_address = 4'd0;
    ce          = 1'b0;
    we          = 1'b0;
    w_bus_in    = 8'h00;
    prog_mode   = 1'b0;
    prog_valid  = 1'b0;
    prog_data   = 8'h00;
    tick();
    test_reset();
    test_prog_full();
    test_prog_toggle_abort();
    test_run_rw();
    test_ignore_prog_done();
    test_reset_mid_prog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sap_ram.md
Name: sap_ram

Overview:
- 16x8 program/data memory addressed by the 4-bit MAR output.
- In RUN mode it answers the MAR: on `ce` it reads the addressed word and drives it onto the W bus one cycle later. On `we` it stores the W bus value at the MAR address.
- In PROG mode it is the loader side. A byte-stream valid/ready port fills addresses 0..15 in order from an auto-incrementing counter, replacing the manual switch-loading step of the SAP-1 flow.

Parameters:
- ADDR_W, 4, address width; must match the MAR output width.
- DATA_W, 8, word width on the W bus.
- DEPTH, 16, number of words; equals 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- mar_address  input  ADDR_W  address from the MAR.
- ce  input  1  read request (RUN state only).
- we  input  1  write request (RUN state only).
- w_bus_in  input  DATA_W  W bus value used for writes.
- w_bus_out  output  DATA_W  read data for the W bus.
- w_bus_oe  output  1  high when w_bus_out is valid and must be driven onto the W bus.
- prog_mode  input  1  level; high requests programming.
- prog_valid  input  1  loader byte valid.
- prog_data  input  DATA_W  loader byte.
- prog_ready  output  1  block accepts a loader byte this cycle.
- prog_done  output  1  all DEPTH words loaded.
- prog_addr  output  ADDR_W  next address the loader will write.

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately):
  - all DEPTH words = 0; state = RUN.
  - w_bus_out = 0, w_bus_oe = 0, prog_ready = 0, prog_done = 0, prog_addr = 0.
- States: RUN, PROG, DONE. All state, memory and output registers are flops.
- RUN:
  - `ce` high at edge N: w_bus_out <= mem[mar_address]; w_bus_oe = 1 for cycle N+1 only. Fixed latency of 1.
  - `ce` held high: a new read every cycle, and w_bus_oe stays high.
  - `ce` low: w_bus_oe <= 0; w_bus_out holds its last value.
  - `we` high at edge N: mem[mar_address] <= w_bus_in.
  - `ce` and `we` together at the same address: the read returns the OLD word; the write still occurs.
  - prog_mode high at an edge: go to PROG with prog_addr <= 0. `ce`/`we` on that same edge are ignored; w_bus_oe <= 0.
- PROG:
  - prog_ready = 1 (decoded from state).
  - prog_valid & prog_ready at an edge: mem[prog_addr] <= prog_data and prog_addr <= prog_addr + 1.
  - prog_valid low: no write, and prog_addr holds.
  - Accept at prog_addr = DEPTH-1: write the word; prog_addr wraps to 0; state goes to DONE.
  - `ce` and `we` are ignored; w_bus_oe = 0.
  - prog_mode low at an edge (abort): go to RUN. Any byte presented on that same edge is NOT written. Words already written are kept. prog_done stays 0.
- DONE:
  - prog_done = 1 and prog_ready = 0; `ce`, `we` and prog_valid are ignored.
  - prog_mode low at an edge: go to RUN; prog_done <= 0.
- prog_done and prog_ready are never high together.
- reset_n low mid-PROG: the memory is cleared and the partial load is lost.
- Widths: prog_addr is ADDR_W bits and wraps modulo DEPTH. There is no width conversion; the MAR address indexes the memory directly.

Decomposition:
- Shared package sap_pkg:
  - ADDR_W and DATA_W localparams;
  - typedef sap_word_t, DATA_W bits;
  - typedef sap_addr_t, ADDR_W bits;
  - enum ram_state_t {RUN, PROG, DONE}.
- One natural sub-module: sap_ram_loader. It holds the PROG/DONE FSM, the prog_addr counter and the handshake, and outputs a write strobe, address and data.
- The top-level sap_ram muxes between loader writes and run-mode writes, and holds the storage array and the read register.

Test Plan:
- Reset with reset_n = 0 mid-cycle, then release; read all 16 addresses with `ce` → every w_bus_out = 0x00; w_bus_oe high exactly one cycle after each `ce`.
- prog_mode = 1, then stream 0x10..0x1F with prog_valid held high → prog_ready high for 16 accepts; prog_done = 1 the cycle after the 16th accept; prog_addr = 0. Drop prog_mode, read addr 5 → 0x15 on cycle N+1.
- PROG with prog_valid toggling every other cycle → prog_addr advances only on accepted cycles. Drop prog_mode after 3 bytes (0xAA, 0xBB, 0xCC) with a 4th byte presented → addr 0..2 = AA/BB/CC; addr 3 keeps its old value; prog_done stays 0.
- RUN: `we` with mar_address = 7, w_bus_in = 0x5A; next cycle `ce` at 7 → w_bus_out = 0x5A, w_bus_oe = 1. Then `ce` + `we` together at 7 with 0x33 → read returns 0x5A; the following read returns 0x33.
- `ce` and `we` asserted during PROG and during DONE → w_bus_oe stays 0 and the memory is unchanged (verified by reading back in RUN).
- reset_n pulsed low after 8 accepted bytes in PROG → immediately state RUN, prog_ready = 0, prog_addr = 0, and all words read back 0x00.
